// File: rtl/iec_drive_arb.sv
// Drive-slot arbiter: tracks each slot's engine type, holds engine resets after a type
// change, and round-robins engine block requests onto the single host SD port.
module iec_drive_arb #(
  parameter int unsigned DRIVES   = 2,
  parameter int unsigned NTYPES   = 3,
  parameter int unsigned RST_HOLD = 16,
  parameter logic [3:0]  LBA_SHL  = 4'b0100
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [DRIVES-1:0]           img_mounted,
  input  logic [31:0]                 img_size,
  input  logic [1:0]                  img_type,
  output logic [DRIVES*NTYPES-1:0]    eng_reset,
  input  logic [DRIVES*NTYPES-1:0]    req_rd,
  input  logic [DRIVES*NTYPES-1:0]    req_wr,
  input  logic [DRIVES*NTYPES*32-1:0] req_lba,
  output logic [DRIVES*NTYPES-1:0]    req_ack,
  output logic                        sd_rd,
  output logic                        sd_wr,
  output logic [31:0]                 sd_lba,
  output logic [1:0]                  sd_slot,
  input  logic                        sd_ack
);

  localparam int unsigned NENG = DRIVES * NTYPES;

  typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        type_q [DRIVES];
  logic [1:0]        type_d [DRIVES];
  logic [7:0]        hold_q [DRIVES];
  logic [7:0]        hold_d [DRIVES];
  logic [NENG-1:0]   eng_reset_q, eng_reset_d;
  logic [1:0]        last_grant_q;
  logic [1:0]        sd_slot_q;
  logic [1:0]        gtype_q;
  logic              rd_q, wr_q;
  logic [31:0]       lba_q;

  logic [DRIVES-1:0] sel_rd, sel_wr, sel_rst, pending;
  logic [31:0]       sel_lba [DRIVES];
  logic              found, load, pick_rd, pick_wr, pick_shl;
  logic [1:0]        pick, pick_type;
  logic [31:0]       pick_lba;

  // Mount tracking; eng_reset is built from next-state so it matches type/hold each cycle.
  always_comb begin
    for (int s = 0; s < int'(DRIVES); s++) begin
      type_d[s] = type_q[s];
      hold_d[s] = (hold_q[s] != 8'd0) ? hold_q[s] - 8'd1 : 8'd0;
      if (img_mounted[s] && (img_size != 32'd0) && (32'(img_type) < NTYPES)) begin
        type_d[s] = img_type;
        if (img_type != type_q[s]) begin
          hold_d[s] = 8'(RST_HOLD);
        end
      end
    end
    eng_reset_d = '0;
    for (int s = 0; s < int'(DRIVES); s++) begin
      for (int t = 0; t < int'(NTYPES); t++) begin
        eng_reset_d[s*int'(NTYPES)+t] = (t != int'(type_d[s])) || (hold_d[s] != 8'd0);
      end
    end
  end

  // Per-slot view of the currently selected engine.
  always_comb begin
    for (int s = 0; s < int'(DRIVES); s++) begin
      sel_rd[s]  = 1'b0;
      sel_wr[s]  = 1'b0;
      sel_rst[s] = 1'b1;
      sel_lba[s] = 32'd0;
      for (int t = 0; t < int'(NTYPES); t++) begin
        if (t == int'(type_q[s])) begin
          sel_rd[s]  = req_rd[s*int'(NTYPES)+t];
          sel_wr[s]  = req_wr[s*int'(NTYPES)+t];
          sel_rst[s] = eng_reset_q[s*int'(NTYPES)+t];
          sel_lba[s] = req_lba[(s*int'(NTYPES)+t)*32 +: 32];
        end
      end
      pending[s] = (sel_rd[s] || sel_wr[s]) && (hold_q[s] == 8'd0) && !sel_rst[s];
    end
  end

  // Round-robin pick, searching from the slot after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 1; i <= int'(DRIVES); i++) begin
      for (int s = 0; s < int'(DRIVES); s++) begin
        if (!found && pending[s] && (s == (int'(last_grant_q) + i) % int'(DRIVES))) begin
          found = 1'b1;
          pick  = 2'(s);
        end
      end
    end
    pick_type = 2'd0;
    pick_rd   = 1'b0;
    pick_wr   = 1'b0;
    pick_lba  = 32'd0;
    for (int s = 0; s < int'(DRIVES); s++) begin
      if (s == int'(pick)) begin
        pick_type = type_q[s];
        pick_rd   = sel_rd[s];
        pick_wr   = sel_wr[s];
        pick_lba  = sel_lba[s];
      end
    end
    pick_shl = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t == int'(pick_type)) begin
        pick_shl = LBA_SHL[t];
      end
    end
    if (pick_shl) begin
      pick_lba = {pick_lba[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          load    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: if (sd_ack) state_d = StXfer;
      StXfer:  if (!sd_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 2'(DRIVES - 1);
      sd_slot_q    <= 2'd0;
      gtype_q      <= 2'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      lba_q        <= 32'd0;
      for (int s = 0; s < int'(DRIVES); s++) begin
        type_q[s] <= 2'd0;
        hold_q[s] <= 8'd0;
        for (int t = 0; t < int'(NTYPES); t++) begin
          eng_reset_q[s*int'(NTYPES)+t] <= (t != 0);
        end
      end
    end else begin
      state_q     <= state_d;
      eng_reset_q <= eng_reset_d;
      for (int s = 0; s < int'(DRIVES); s++) begin
        type_q[s] <= type_d[s];
        hold_q[s] <= hold_d[s];
      end
      // The request is frozen at grant so later drops or remounts cannot disturb it.
      if (load) begin
        sd_slot_q <= pick;
        gtype_q   <= pick_type;
        rd_q      <= pick_rd;
        wr_q      <= pick_wr;
        lba_q     <= pick_lba;
      end
      if (state_q == StDone) begin
        last_grant_q <= sd_slot_q;
      end
    end
  end

  always_comb begin
    sd_rd   = (state_q == StIssue) && rd_q;
    sd_wr   = (state_q == StIssue) && wr_q && !rd_q;
    req_ack = '0;
    for (int e = 0; e < int'(NENG); e++) begin
      req_ack[e] = ((state_q == StIssue) || (state_q == StXfer)) && sd_ack &&
                   (e == int'(sd_slot_q) * int'(NTYPES) + int'(gtype_q));
    end
  end

  assign eng_reset = eng_reset_q;
  assign sd_lba    = lba_q;
  assign sd_slot   = sd_slot_q;

endmodule

// File: doc/iec_drive_arb.md
IEC_DRIVE_ARB -- requirements
Module: iec_drive_arb

Interface
- REQ-001 SHALL have parameter DRIVES, default 2, number of drive slots; legal range 1..4.
- REQ-002 SHALL have parameter NTYPES, default 3, number of drive engine types per slot; legal range 2..4.
- REQ-003 SHALL have parameter RST_HOLD, default 16, number of cycles an engine reset is held after a type change; legal range 1..255.
- REQ-004 SHALL have parameter LBA_SHL, default 3'b100, per-type bitmask; a set bit means that type's LBA is shifted left by 1.
- REQ-005 clk_sys  in  1  sole clock; all logic is rising-edge.
- REQ-006 reset  in  1  asynchronous, active-high reset.
- REQ-007 img_mounted  in  DRIVES  per-slot mount strobe, one cycle.
- REQ-008 img_size  in  32  image size qualifying img_mounted.
- REQ-009 img_type  in  2  engine type code for the mounting image.
- REQ-010 eng_reset  out  DRIVES*NTYPES  per slot/type engine reset, index slot*NTYPES+type.
- REQ-011 req_rd, req_wr  in  DRIVES*NTYPES each  engine block read/write requests, level.
- REQ-012 req_lba  in  DRIVES*NTYPES*32  engine LBAs, flattened.
- REQ-013 req_ack  out  DRIVES*NTYPES  sd_ack routed to the granted engine.
- REQ-014 sd_rd, sd_wr  out  1  host request.
- REQ-015 sd_lba  out  32  host LBA.
- REQ-016 sd_slot  out  2  index of the granted slot.
- REQ-017 sd_ack  in  1  host acknowledge, high for the duration of the transfer.

Function
- REQ-018 Per slot, type[s] SHALL latch img_type on img_mounted[s]=1 with img_size!=0; a mount with size 0 SHALL leave the type unchanged.
- REQ-019 img_type >= NTYPES SHALL be ignored; the type is unchanged and no hold starts.
- REQ-020 A latch that changes type[s] SHALL load hold[s]=RST_HOLD; hold[s] SHALL count down by 1 per cycle to 0 and saturate there.
- REQ-021 eng_reset[s,t] SHALL be registered and equal (t!=type[s]) OR (hold[s]!=0).
- REQ-022 A slot is pending when the selected engine's req_rd or req_wr is 1, the slot is not in hold, and its eng_reset is 0.
- REQ-023 The FSM SHALL have states IDLE, ISSUE, XFER and DONE.
- REQ-024 IDLE: when any slot is pending, the FSM SHALL select a slot by round-robin starting at last_grant+1 modulo DRIVES, register it as sd_slot, and go to ISSUE on the next cycle.
- REQ-025 ISSUE: the FSM SHALL drive sd_rd=req_rd, or sd_wr=req_wr when req_rd=0 (read wins if both are set), and sd_lba=req_lba, shifted left by 1 when LBA_SHL[type] is set, with the upper bit dropped to keep 32 bits; the request is latched at ISSUE entry.
- REQ-026 ISSUE to XFER on sd_ack=1; sd_rd and sd_wr SHALL deassert in the cycle after sd_ack is first seen.
- REQ-027 XFER to DONE on sd_ack=0.
- REQ-028 DONE: the FSM SHALL update last_grant=sd_slot and return to IDLE; minimum spacing between grants is 4 cycles.
- REQ-029 req_ack[g] SHALL equal sd_ack combinationally for the granted slot/type during ISSUE and XFER, and 0 for all others.
- REQ-030 A type change or hold on the granted slot during ISSUE or XFER SHALL NOT abort the transaction; it completes, and req_ack goes to the latched grant engine.
- REQ-031 A request dropped before sd_ack SHALL NOT retract sd_rd or sd_wr; the host transaction completes.
- REQ-032 With DRIVES=1, round-robin SHALL degenerate to always granting slot 0.

Reset
- REQ-033 On reset, type[*]=0 and hold[*]=0.
- REQ-034 On reset, the FSM goes to IDLE and last_grant=DRIVES-1.
- REQ-035 On reset, sd_rd=0, sd_wr=0, sd_lba=0, sd_slot=0 and req_ack=0.
- REQ-036 On reset, eng_reset[s,t]=1 for t!=0 and 0 for t=0.
- REQ-037 Reset asserted mid-transaction SHALL drop sd_rd, sd_wr and the grant immediately and asynchronously.

Verification
- REQ-038 Mount slot 1 with type 2, size 819200 -> eng_reset[1,*] all 1 for 16 cycles, then only [1,2]=0; type-2 req_lba 0x100 -> sd_lba=0x200, sd_slot=1.
- REQ-039 Slots 0 and 1 both requesting continuously after reset -> grant order 0,1,0,1; each sd_rd pulse lasts until the cycle after sd_ack.
- REQ-040 req_rd=req_wr=1 on type 0, LBA 0x11 -> sd_rd=1, sd_wr=0, sd_lba=0x11.
- REQ-041 Slot 0 remounted to type 1 during XFER -> req_ack stays routed to [0,0] until sd_ack falls; the next grant to slot 0 comes only after the hold expires.
- REQ-042 Mount with size 0 or img_type=3 with NTYPES=3 -> type unchanged, no eng_reset pulse.
- REQ-043 reset asserted in XFER -> sd_rd, sd_wr and req_ack are 0 in the same cycle; after release, the first grant goes to slot 0.
